// File: rtl/sdram_port_arbiter_pkg.sv
// rtl/sdram_port_arbiter_pkg.sv - shared state encoding, default widths and helpers for the SDRAM port arbiter
package sdram_port_arbiter_pkg;

   localparam int ADDR_W_DEF = 21;
   localparam int LEN_W_DEF  = 9;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_WR_REQ   = 3'd1;
   localparam logic [2:0] ST_WR_BURST = 3'd2;
   localparam logic [2:0] ST_RD_REQ   = 3'd3;
   localparam logic [2:0] ST_RD_BURST = 3'd4;

   function automatic logic [1:0] port_onehot(input logic port);
      return port ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// rtl/sdram_port_arbiter_if.sv - port-side and controller-side bundle of the SDRAM port arbiter
interface sdram_port_arbiter_if
   import sdram_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
);
   logic                  sdram_init_done;
   logic [1:0]            port_wr_req;
   logic [2*ADDR_W-1:0]   port_wr_addr;
   logic [2*LEN_W-1:0]    port_wr_len;
   logic [31:0]           port_din;
   logic [1:0]            port_wr_ack;
   logic [1:0]            port_rd_req;
   logic [2*ADDR_W-1:0]   port_rd_addr;
   logic [2*LEN_W-1:0]    port_rd_len;
   logic [1:0]            port_rd_ack;
   logic [15:0]           port_dout;
   logic                  sdram_wr_req;
   logic                  sdram_rd_req;
   logic [ADDR_W-1:0]     sdram_wr_addr;
   logic [ADDR_W-1:0]     sdram_rd_addr;
   logic [LEN_W-1:0]      sdram_wr_burst;
   logic [LEN_W-1:0]      sdram_rd_burst;
   logic                  sdram_wr_ack;
   logic                  sdram_rd_ack;
   logic [15:0]           sdram_din;
   logic [15:0]           sdram_dout;
   logic                  grant_port;
   logic                  busy;

   modport slave (
      input  sdram_init_done, port_wr_req, port_wr_addr, port_wr_len, port_din,
             port_rd_req, port_rd_addr, port_rd_len, sdram_wr_ack, sdram_rd_ack, sdram_dout,
      output port_wr_ack, port_rd_ack, port_dout, sdram_wr_req, sdram_rd_req,
             sdram_wr_addr, sdram_rd_addr, sdram_wr_burst, sdram_rd_burst, sdram_din,
             grant_port, busy
   );

   modport master (
      output sdram_init_done, port_wr_req, port_wr_addr, port_wr_len, port_din,
             port_rd_req, port_rd_addr, port_rd_len, sdram_wr_ack, sdram_rd_ack, sdram_dout,
      input  port_wr_ack, port_rd_ack, port_dout, sdram_wr_req, sdram_rd_req,
             sdram_wr_addr, sdram_rd_addr, sdram_wr_burst, sdram_rd_burst, sdram_din,
             grant_port, busy
   );

endinterface

// File: rtl/sdram_port_arbiter_rr_arb2.sv
// rtl/sdram_port_arbiter_rr_arb2.sv - two-way round-robin picker whose pointer skips past the last served port
module rr_arb2 (
   input  logic       clk_ref,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       adv_i,
   input  logic       done_port_i,
   output logic       pick_o
);
   logic ptr_q;
   logic ptr_d;

   // Pointed-to port wins if requesting, otherwise the other one.
   always_comb begin
      pick_o = req_i[ptr_q] ? ptr_q : ~ptr_q;
      ptr_d  = adv_i ? ~done_port_i : ptr_q;
   end

   always_ff @(posedge clk_ref or negedge rst_n) begin
      if (!rst_n) ptr_q <= 1'b0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-port, two-class SDRAM burst arbiter with write-streak limit
module sdram_port_arbiter
   import sdram_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF,
   parameter int WR_MAX = 4
) (
   input  logic                clk_ref,
   input  logic                rst_n,
   sdram_port_arbiter_if.slave bus
);
   localparam int SW = $clog2(WR_MAX + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(WR_MAX);

   logic [2:0]        state_q, state_d;
   logic              grant_q, grant_d;
   logic              wr_req_q, wr_req_d, rd_req_q, rd_req_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
   logic [LEN_W-1:0]  wr_len_q, wr_len_d, rd_len_q, rd_len_d;
   logic              wr_ack_q, rd_ack_q;
   logic [SW-1:0]     streak_q, streak_d;

   logic wr_any, rd_any, take_wr, wr_pick, rd_pick;
   logic wr_phase, rd_phase, wr_done, rd_done;

   assign wr_any   = |bus.port_wr_req;
   assign rd_any   = |bus.port_rd_req;
   assign take_wr  = wr_any && !(streak_q == STREAK_MAX && rd_any);
   assign wr_phase = (state_q == ST_WR_REQ) || (state_q == ST_WR_BURST);
   assign rd_phase = (state_q == ST_RD_REQ) || (state_q == ST_RD_BURST);
   // A burst ends on the falling edge of the controller ack.
   assign wr_done  = (state_q == ST_WR_BURST) && wr_ack_q && !bus.sdram_wr_ack;
   assign rd_done  = (state_q == ST_RD_BURST) && rd_ack_q && !bus.sdram_rd_ack;

   rr_arb2 u_wr_arb (
      .clk_ref(clk_ref), .rst_n(rst_n), .req_i(bus.port_wr_req),
      .adv_i(wr_done), .done_port_i(grant_q), .pick_o(wr_pick)
   );

   rr_arb2 u_rd_arb (
      .clk_ref(clk_ref), .rst_n(rst_n), .req_i(bus.port_rd_req),
      .adv_i(rd_done), .done_port_i(grant_q), .pick_o(rd_pick)
   );

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      wr_req_d  = wr_req_q;
      rd_req_d  = rd_req_q;
      wr_addr_d = wr_addr_q;
      rd_addr_d = rd_addr_q;
      wr_len_d  = wr_len_q;
      rd_len_d  = rd_len_q;
      streak_d  = streak_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.sdram_init_done && take_wr) begin
               grant_d   = wr_pick;
               wr_addr_d = wr_pick ? bus.port_wr_addr[ADDR_W +: ADDR_W] : bus.port_wr_addr[0 +: ADDR_W];
               wr_len_d  = wr_pick ? bus.port_wr_len[LEN_W +: LEN_W] : bus.port_wr_len[0 +: LEN_W];
               wr_req_d  = 1'b1;
               state_d   = ST_WR_REQ;
               if (!rd_any) streak_d = '0;
            end else if (bus.sdram_init_done && rd_any) begin
               grant_d   = rd_pick;
               rd_addr_d = rd_pick ? bus.port_rd_addr[ADDR_W +: ADDR_W] : bus.port_rd_addr[0 +: ADDR_W];
               rd_len_d  = rd_pick ? bus.port_rd_len[LEN_W +: LEN_W] : bus.port_rd_len[0 +: LEN_W];
               rd_req_d  = 1'b1;
               state_d   = ST_RD_REQ;
            end
         end
         ST_WR_REQ: begin
            if (bus.sdram_wr_ack) begin
               wr_req_d = 1'b0;
               state_d  = ST_WR_BURST;
            end
         end
         ST_WR_BURST: begin
            if (wr_done) begin
               state_d = ST_IDLE;
               if (streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
            end
         end
         ST_RD_REQ: begin
            if (bus.sdram_rd_ack) begin
               rd_req_d = 1'b0;
               state_d  = ST_RD_BURST;
            end
         end
         ST_RD_BURST: begin
            if (rd_done) begin
               state_d  = ST_IDLE;
               streak_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_ref or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         grant_q   <= 1'b0;
         wr_req_q  <= 1'b0;
         rd_req_q  <= 1'b0;
         wr_addr_q <= '0;
         rd_addr_q <= '0;
         wr_len_q  <= '0;
         rd_len_q  <= '0;
         wr_ack_q  <= 1'b0;
         rd_ack_q  <= 1'b0;
         streak_q  <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         wr_req_q  <= wr_req_d;
         rd_req_q  <= rd_req_d;
         wr_addr_q <= wr_addr_d;
         rd_addr_q <= rd_addr_d;
         wr_len_q  <= wr_len_d;
         rd_len_q  <= rd_len_d;
         wr_ack_q  <= bus.sdram_wr_ack;
         rd_ack_q  <= bus.sdram_rd_ack;
         streak_q  <= streak_d;
      end
   end

   assign bus.sdram_wr_req   = wr_req_q;
   assign bus.sdram_rd_req   = rd_req_q;
   assign bus.sdram_wr_addr  = wr_addr_q;
   assign bus.sdram_rd_addr  = rd_addr_q;
   assign bus.sdram_wr_burst = wr_len_q;
   assign bus.sdram_rd_burst = rd_len_q;
   assign bus.grant_port     = grant_q;
   assign bus.busy           = (state_q != ST_IDLE);
   assign bus.port_wr_ack    = {2{bus.sdram_wr_ack && wr_phase}} & port_onehot(grant_q);
   assign bus.port_rd_ack    = {2{bus.sdram_rd_ack && rd_phase}} & port_onehot(grant_q);
   assign bus.sdram_din      = grant_q ? bus.port_din[31:16] : bus.port_din[15:0];
   assign bus.port_dout      = bus.sdram_dout;

endmodule
